// File: rtl/evaluation_pkg.sv
// Shared types and widths for the chromosome evaluation sequencer.
package evaluation_pkg;

    localparam int SEQ_W        = 4;
    localparam int CYCLE_W      = 32;
    localparam int EVAL_COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } eval_state_e;

endpackage

// File: rtl/chromosome_evaluation_sequencer_if.sv
// Control/status bundle between the GA control FSM (master) and the sequencer (slave).
interface chromosome_evaluation_sequencer_if;

    logic                                    iStart;
    logic                                    iAbort;
    logic                                    iResultAck;
    logic                                    oProcessing;
    logic                                    oKeepResult;
    logic [evaluation_pkg::CYCLE_W-1:0]      oClockCycleCounter;
    logic [evaluation_pkg::SEQ_W-1:0]        oCurrentSequence;
    logic                                    oBusy;
    logic                                    oDone;
    logic                                    oAborted;
    logic [evaluation_pkg::EVAL_COUNT_W-1:0] oEvaluationCount;

    modport master (
        output iStart, iAbort, iResultAck,
        input  oProcessing, oKeepResult, oClockCycleCounter, oCurrentSequence,
               oBusy, oDone, oAborted, oEvaluationCount
    );

    modport slave (
        input  iStart, iAbort, iResultAck,
        output oProcessing, oKeepResult, oClockCycleCounter, oCurrentSequence,
               oBusy, oDone, oAborted, oEvaluationCount
    );

endinterface

// File: rtl/eval_step_counter.sv
// Per-sequence cycle counter and sequence index; flags the final cycle of the final sequence.
module eval_step_counter
    import evaluation_pkg::*;
#(
    parameter int unsigned CYCLES_PER_SEQUENCE = 16,
    parameter int unsigned NUM_SEQUENCES       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    output logic [CYCLE_W-1:0] count,
    output logic [SEQ_W-1:0]   seq,
    output logic               last_step
);

    localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(CYCLES_PER_SEQUENCE - 1);
    localparam logic [SEQ_W-1:0]   LAST_SEQ   = SEQ_W'(NUM_SEQUENCES - 1);

    logic [CYCLE_W-1:0] count_q, count_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;

    always_comb begin
        count_d = count_q;
        seq_d   = seq_q;
        if (clear) begin
            count_d = '0;
            seq_d   = '0;
        end else if (advance) begin
            if (count_q == LAST_CYCLE) begin
                count_d = '0;
                seq_d   = seq_q + 4'd1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            seq_q   <= '0;
        end else begin
            count_q <= count_d;
            seq_q   <= seq_d;
        end
    end

    assign count     = count_q;
    assign seq       = seq_q;
    assign last_step = (count_q == LAST_CYCLE) && (seq_q == LAST_SEQ);

endmodule

// File: rtl/chromosome_evaluation_sequencer.sv
// Drives the error-sum accumulator through clear, per-sequence processing windows and result hold.
module chromosome_evaluation_sequencer
    import evaluation_pkg::*;
#(
    parameter int unsigned CYCLES_PER_SEQUENCE = 16,
    parameter int unsigned NUM_SEQUENCES       = 16
) (
    input logic                               iClock,
    input logic                               iReset,
    chromosome_evaluation_sequencer_if.slave  bus
);

    if (CYCLES_PER_SEQUENCE == 0) begin : g_bad_cycles
        $error("CYCLES_PER_SEQUENCE must be at least 1");
    end
    if (NUM_SEQUENCES == 0 || NUM_SEQUENCES > (1 << SEQ_W)) begin : g_bad_sequences
        $error("NUM_SEQUENCES must be in 1..16");
    end

    eval_state_e             state_q, state_d;
    logic                    processing_q, processing_d;
    logic                    keep_q, keep_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;
    logic [EVAL_COUNT_W-1:0] eval_count_q, eval_count_d;

    logic               step_clear;
    logic               step_advance;
    logic               last_step;
    logic [CYCLE_W-1:0] step_count;
    logic [SEQ_W-1:0]   step_seq;

    eval_step_counter #(
        .CYCLES_PER_SEQUENCE (CYCLES_PER_SEQUENCE),
        .NUM_SEQUENCES       (NUM_SEQUENCES)
    ) u_step_counter (
        .clk       (iClock),
        .rst       (iReset),
        .clear     (step_clear),
        .advance   (step_advance),
        .count     (step_count),
        .seq       (step_seq),
        .last_step (last_step)
    );

    // Abort wins over the end-of-evaluation transition; outputs decode from the next state.
    always_comb begin
        state_d      = state_q;
        aborted_d    = 1'b0;
        eval_count_d = eval_count_q;
        step_advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.iStart) state_d = CLEAR;
            end
            CLEAR: begin
                if (bus.iAbort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.iAbort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (last_step) begin
                    state_d      = DONE;
                    eval_count_d = eval_count_q + 16'd1;
                end else begin
                    step_advance = 1'b1;
                end
            end
            DONE: begin
                if (bus.iResultAck) state_d = bus.iStart ? CLEAR : IDLE;
            end
            default: state_d = IDLE;
        endcase
        step_clear   = (state_d == CLEAR);
        processing_d = (state_d == RUN);
        keep_d       = (state_d != CLEAR);
        busy_d       = (state_d == CLEAR) || (state_d == RUN);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q      <= IDLE;
            processing_q <= 1'b0;
            keep_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            eval_count_q <= '0;
        end else begin
            state_q      <= state_d;
            processing_q <= processing_d;
            keep_q       <= keep_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            eval_count_q <= eval_count_d;
        end
    end

    assign bus.oProcessing        = processing_q;
    assign bus.oKeepResult        = keep_q;
    assign bus.oClockCycleCounter = step_count;
    assign bus.oCurrentSequence   = step_seq;
    assign bus.oBusy              = busy_q;
    assign bus.oDone              = done_q;
    assign bus.oAborted           = aborted_q;
    assign bus.oEvaluationCount   = eval_count_q;

endmodule

// File: tb/tb_chromosome_evaluation_sequencer.sv
// Self-checking bench: two sequencer instances (4x3 and 1x16) against a cycle-count based model.
module tb_chromosome_evaluation_sequencer;

    localparam int unsigned C_A = 4;
    localparam int unsigned S_A = 3;
    localparam int unsigned C_B = 1;
    localparam int unsigned S_B = 16;

    typedef struct packed {
        logic        processing;
        logic        keep;
        logic        busy;
        logic        done;
        logic        aborted;
        logic [31:0] counter;
        logic [3:0]  seq;
        logic [15:0] evals;
    } obs_t;

    // Model tracks an evaluation as "k processing cycles elapsed"; indices are derived from k.
    typedef struct {
        bit          evaluating;
        bit          in_clear;
        bit          holding;
        bit          aborted;
        bit          just_reset;
        int unsigned k;
        logic [15:0] evals;
    } model_t;

    typedef struct {
        bit   rst;
        bit   start;
        bit   abort;
        bit   ack;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   tests = 0;
    int   failed = 0;
    model_t ma, mb;
    vec_t   vecs[9];

    chromosome_evaluation_sequencer_if bus_a();
    chromosome_evaluation_sequencer_if bus_b();

    chromosome_evaluation_sequencer #(
        .CYCLES_PER_SEQUENCE (C_A),
        .NUM_SEQUENCES       (S_A)
    ) dut_a (
        .iClock (clk),
        .iReset (rst_a),
        .bus    (bus_a)
    );

    chromosome_evaluation_sequencer #(
        .CYCLES_PER_SEQUENCE (C_B),
        .NUM_SEQUENCES       (S_B)
    ) dut_b (
        .iClock (clk),
        .iReset (rst_b),
        .bus    (bus_b)
    );

    always #5 clk = ~clk;

    function automatic model_t model_next(model_t m, bit rst, bit start, bit abort, bit ack,
                                          int unsigned total);
        model_t n = m;
        n.aborted    = 1'b0;
        n.just_reset = 1'b0;
        if (rst) begin
            n = '{default: '0};
            n.just_reset = 1'b1;
        end else if (m.evaluating) begin
            if (abort) begin
                n.evaluating = 1'b0;
                n.in_clear   = 1'b0;
                n.aborted    = 1'b1;
            end else if (m.in_clear) begin
                n.in_clear = 1'b0;
            end else if (m.k == total - 1) begin
                n.evaluating = 1'b0;
                n.holding    = 1'b1;
                n.evals      = m.evals + 16'd1;
            end else begin
                n.k = m.k + 1;
            end
        end else if (m.holding) begin
            if (ack) begin
                n.holding = 1'b0;
                if (start) begin
                    n.evaluating = 1'b1;
                    n.in_clear   = 1'b1;
                    n.k          = 0;
                end
            end
        end else if (start) begin
            n.evaluating = 1'b1;
            n.in_clear   = 1'b1;
            n.k          = 0;
        end
        return n;
    endfunction

    function automatic obs_t model_obs(model_t m, int unsigned c);
        obs_t o;
        o.processing = m.evaluating && !m.in_clear;
        o.keep       = !m.just_reset && !(m.evaluating && m.in_clear);
        o.busy       = m.evaluating;
        o.done       = m.holding;
        o.aborted    = m.aborted;
        o.counter    = 32'(m.k % c);
        o.seq        = 4'(m.k / c);
        o.evals      = m.evals;
        return o;
    endfunction

    function automatic obs_t get_a();
        return '{bus_a.oProcessing, bus_a.oKeepResult, bus_a.oBusy, bus_a.oDone, bus_a.oAborted,
                 bus_a.oClockCycleCounter, bus_a.oCurrentSequence, bus_a.oEvaluationCount};
    endfunction

    function automatic obs_t get_b();
        return '{bus_b.oProcessing, bus_b.oKeepResult, bus_b.oBusy, bus_b.oDone, bus_b.oAborted,
                 bus_b.oClockCycleCounter, bus_b.oCurrentSequence, bus_b.oEvaluationCount};
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("proc=%0b keep=%0b busy=%0b done=%0b abrt=%0b cnt=%0d seq=%0d evals=%0d",
                         o.processing, o.keep, o.busy, o.done, o.aborted, o.counter, o.seq, o.evals);
    endfunction

    task automatic check_output(input string name, input obs_t act, input obs_t exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; both DUTs are compared to the model at the next falling edge.
    task automatic apply_stimulus(input bit ra, input bit sa, input bit aa, input bit ka,
                                  input bit rb, input bit sb, input bit ab, input bit kb);
        rst_a            = ra;
        bus_a.iStart     = sa;
        bus_a.iAbort     = aa;
        bus_a.iResultAck = ka;
        rst_b            = rb;
        bus_b.iStart     = sb;
        bus_b.iAbort     = ab;
        bus_b.iResultAck = kb;
        @(posedge clk);
        ma = model_next(ma, ra, sa, aa, ka, C_A * S_A);
        mb = model_next(mb, rb, sb, ab, kb, C_B * S_B);
        @(negedge clk);
        check_output("model_a", get_a(), model_obs(ma, C_A));
        check_output("model_b", get_b(), model_obs(mb, C_B));
    endtask

    task automatic step_a(input bit sa, input bit aa, input bit ka);
        apply_stimulus(1'b0, sa, aa, ka, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        obs_t o;
        ma = '{default: '0};
        mb = '{default: '0};
        bus_a.iStart = 1'b0; bus_a.iAbort = 1'b0; bus_a.iResultAck = 1'b0;
        bus_b.iStart = 1'b0; bus_b.iAbort = 1'b0; bus_b.iResultAck = 1'b0;

        //            rst  st   ab   ack    proc keep busy done abrt cnt    seq   evals
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 16'd0}};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 16'd0}};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 16'd0}};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 16'd0}};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 16'd0}};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 4'd0, 16'd0}};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 4'd0, 16'd0}};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 4'd0, 16'd0}};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 4'd1, 16'd0}};

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].start, vecs[i].abort, vecs[i].ack,
                           1'b1, 1'b0, 1'b0, 1'b0);
            check_output($sformatf("vec%0d", i), get_a(), vecs[i].exp);
        end

        // Finish the first evaluation: RUN cycles with k = 5..11, then DONE.
        for (int i = 0; i < 7; i++) step_a(1'b0, 1'b0, 1'b0);
        check_value("last_run_cnt", bus_a.oClockCycleCounter, 32'd3);
        check_value("last_run_seq", bus_a.oCurrentSequence, 32'd2);
        step_a(1'b0, 1'b0, 1'b0);
        check_value("done_rise", bus_a.oDone, 32'd1);
        check_value("done_proc", bus_a.oProcessing, 32'd0);
        check_value("done_evals", bus_a.oEvaluationCount, 32'd1);

        // DONE holds while unacknowledged; abort and lone start are ignored there.
        for (int i = 0; i < 10; i++) begin
            step_a(i == 3, i == 5, 1'b0);
            o = get_a();
            check_value("hold_done", o.done, 32'd1);
            check_value("hold_cnt", o.counter, 32'd3);
            check_value("hold_seq", o.seq, 32'd2);
        end
        step_a(1'b0, 1'b0, 1'b1);
        check_value("ack_done_fall", bus_a.oDone, 32'd0);
        check_value("ack_idle_keep", bus_a.oKeepResult, 32'd1);

        // Second evaluation, then back-to-back start with acknowledge.
        step_a(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) step_a(1'b0, 1'b0, 1'b0);
        check_value("eval2_evals", bus_a.oEvaluationCount, 32'd2);
        step_a(1'b1, 1'b0, 1'b1);
        check_value("b2b_busy", bus_a.oBusy, 32'd1);
        check_value("b2b_keep", bus_a.oKeepResult, 32'd0);
        check_value("b2b_done", bus_a.oDone, 32'd0);
        for (int i = 0; i < 12; i++) begin
            step_a(1'b0, 1'b0, 1'b0);
            check_value("b2b_proc", bus_a.oProcessing, 32'd1);
        end
        step_a(1'b0, 1'b0, 1'b0);
        check_value("eval3_evals", bus_a.oEvaluationCount, 32'd3);
        step_a(1'b0, 1'b0, 1'b1);

        // Abort at RUN cycle 5, with a stray start during RUN that must not restart anything.
        step_a(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) step_a(i == 3, 1'b0, 1'b0);
        check_value("run5_cnt", bus_a.oClockCycleCounter, 32'd0);
        check_value("run5_seq", bus_a.oCurrentSequence, 32'd1);
        step_a(1'b0, 1'b1, 1'b0);
        o = get_a();
        check_value("abort_pulse", o.aborted, 32'd1);
        check_value("abort_busy", o.busy, 32'd0);
        check_value("abort_done", o.done, 32'd0);
        check_value("abort_evals", o.evals, 32'd3);
        step_a(1'b0, 1'b0, 1'b0);
        check_value("abort_one_cycle", bus_a.oAborted, 32'd0);

        // Reset at RUN cycle 7.
        step_a(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step_a(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("reset_mid_run", get_a(), '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 16'd0});
        step_a(1'b0, 1'b0, 1'b0);
        check_value("post_reset_keep", bus_a.oKeepResult, 32'd1);

        // 16 sequences of one cycle each on the second instance.
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_value("b_clear_keep", bus_b.oKeepResult, 32'd0);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_value("b_proc", bus_b.oProcessing, 32'd1);
            check_value("b_seq", bus_b.oCurrentSequence, i);
            check_value("b_cnt", bus_b.oClockCycleCounter, 32'd0);
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_value("b_done", bus_b.oDone, 32'd1);
        check_value("b_done_seq", bus_b.oCurrentSequence, 32'd15);
        check_value("b_evals", bus_b.oEvaluationCount, 32'd1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic on both instances against the model.
        for (int i = 0; i < 1500; i++) begin
            apply_stimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                           $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0,
                           $urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                           $urandom_range(0, 30) == 0, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
